// File: rtl/led_sequencer.sv
// Parametrised LED pattern generator: rotate left/right, bounce and bar fill
// across N_LEDS outputs, stepping once every period+1 clock cycles.
module led_sequencer #(
  parameter int N_LEDS = 4,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  period,
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0] cnt_r;
  logic [POS_W-1:0] pos_r;
  dir_t             dir_r;

  logic             step_s;
  logic [POS_W-1:0] pos_nxt_s;
  dir_t             dir_nxt_s;

  // Bar fill lights every LED up to and including pos; other modes are one-hot.
  function automatic logic [N_LEDS-1:0] decode(input logic [POS_W-1:0] p,
                                               input logic [1:0] m);
    logic [N_LEDS-1:0] d;
    d = {N_LEDS{1'b0}};
    for (int i = 0; i < N_LEDS; i++) begin
      if (m == 2'b11) begin
        d[i] = (i <= int'(p));
      end else begin
        d[i] = (i == int'(p));
      end
    end
    return d;
  endfunction

  // Next position and bounce direction; endpoints are never repeated in bounce.
  always_comb begin
    step_s    = en && (cnt_r >= period);
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    if (step_s) begin
      case (mode)
        2'b01: begin
          pos_nxt_s = (pos_r == POS_ZERO) ? POS_LAST : pos_r - POS_ONE;
        end
        2'b10: begin
          if (dir_r == DIR_UP) begin
            if (pos_r >= POS_LAST) begin
              dir_nxt_s = DIR_DOWN;
              pos_nxt_s = POS_PREV;
            end else begin
              pos_nxt_s = pos_r + POS_ONE;
            end
          end else begin
            if (pos_r == POS_ZERO) begin
              dir_nxt_s = DIR_UP;
              pos_nxt_s = POS_ONE;
            end else begin
              pos_nxt_s = pos_r - POS_ONE;
            end
          end
        end
        default: begin
          pos_nxt_s = (pos_r >= POS_LAST) ? POS_ZERO : pos_r + POS_ONE;
        end
      endcase
    end else begin
      pos_nxt_s = pos_r;
      dir_nxt_s = dir_r;
    end
  end

  // Prescaler, position state and registered LED/tick outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
      pos_r <= POS_ZERO;
      dir_r <= DIR_UP;
      tick  <= 1'b0;
      leds  <= {{(N_LEDS-1){1'b0}}, 1'b1};
    end else begin
      if (step_s) begin
        cnt_r <= {DIV_W{1'b0}};
      end else if (en) begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
      tick  <= step_s;
      // Decoding from the next position keeps leds aligned with tick.
      leds  <= decode(pos_nxt_s, mode);
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer (N=4 instance plus an N=2
// instance for the short bounce case).
module tb_led_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] period;
  logic [3:0]  leds;
  logic        tick;
  logic [1:0]  leds2;
  logic        tick2;

  int checks = 0;
  int fails  = 0;

  led_sequencer #(.N_LEDS(4), .DIV_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
    .leds(leds), .tick(tick)
  );

  led_sequencer #(.N_LEDS(2), .DIV_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
    .leds(leds2), .tick(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_rot_l [12] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] exp_rot_r [5]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [3:0] exp_bnc4  [8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};
  logic [1:0] exp_bnc2  [8]  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [3:0] exp_fill  [12] = '{4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111,
                                 4'b1111, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111};

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [23:0] p);
    rst_n  = 1'b0;
    en     = 1'b1;
    mode   = m;
    period = p;
    step_clk();
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2'b00, 24'd2);
    checks++;
    if (leds !== 4'b0001 || tick !== 1'b0) begin
      $display("FAIL reset: leds=%b tick=%b, want leds=0001 tick=0", leds, tick);
      fails++;
    end
    checks++;
    if (leds2 !== 2'b01 || tick2 !== 1'b0) begin
      $display("FAIL reset_n2: leds=%b tick=%b, want leds=01 tick=0", leds2, tick2);
      fails++;
    end
  endtask

  task automatic test_rotate_left();
    do_reset(2'b00, 24'd2);
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      checks++;
      if (leds !== exp_rot_l[k-1] || tick !== (k % 3 == 0)) begin
        $display("FAIL rot_left edge %0d: leds=%b tick=%b, want leds=%b tick=%0d",
                 k, leds, tick, exp_rot_l[k-1], (k % 3 == 0));
        fails++;
      end
    end
  endtask

  task automatic test_rotate_right();
    do_reset(2'b01, 24'd0);
    for (int k = 0; k < 5; k++) begin
      step_clk();
      checks++;
      if (leds !== exp_rot_r[k] || tick !== 1'b1) begin
        $display("FAIL rot_right edge %0d: leds=%b tick=%b, want leds=%b tick=1",
                 k + 1, leds, tick, exp_rot_r[k]);
        fails++;
      end
    end
  endtask

  task automatic test_bounce();
    do_reset(2'b10, 24'd0);
    for (int k = 0; k < 8; k++) begin
      step_clk();
      checks++;
      if (leds !== exp_bnc4[k]) begin
        $display("FAIL bounce_n4 edge %0d: leds=%b, want %b", k + 1, leds, exp_bnc4[k]);
        fails++;
      end
      checks++;
      if (leds2 !== exp_bnc2[k] || tick2 !== 1'b1) begin
        $display("FAIL bounce_n2 edge %0d: leds=%b tick=%b, want leds=%b tick=1",
                 k + 1, leds2, tick2, exp_bnc2[k]);
        fails++;
      end
    end
  endtask

  task automatic test_fill_mode_change();
    do_reset(2'b11, 24'd1);
    for (int k = 0; k < 12; k++) begin
      step_clk();
      checks++;
      if (leds !== exp_fill[k]) begin
        $display("FAIL fill edge %0d: leds=%b, want %b", k + 1, leds, exp_fill[k]);
        fails++;
      end
    end
    mode = 2'b00;
    step_clk();
    checks++;
    if (leds !== 4'b0100 || tick !== 1'b0) begin
      $display("FAIL mode_change redecode: leds=%b tick=%b, want leds=0100 tick=0", leds, tick);
      fails++;
    end
    step_clk();
    checks++;
    if (leds !== 4'b1000 || tick !== 1'b1) begin
      $display("FAIL mode_change step: leds=%b tick=%b, want leds=1000 tick=1", leds, tick);
      fails++;
    end
  endtask

  task automatic test_enable_freeze();
    do_reset(2'b00, 24'd3);
    step_clk();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_clk();
      checks++;
      if (leds !== 4'b0001 || tick !== 1'b0) begin
        $display("FAIL freeze cycle %0d: leds=%b tick=%b, want leds=0001 tick=0", k, leds, tick);
        fails++;
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step_clk();
      checks++;
      if (leds !== ((k == 3) ? 4'b0010 : 4'b0001) || tick !== (k == 3)) begin
        $display("FAIL resume edge %0d: leds=%b tick=%b, want leds=%b tick=%0d",
                 k, leds, tick, ((k == 3) ? 4'b0010 : 4'b0001), (k == 3));
        fails++;
      end
    end
  endtask

  task automatic test_period_drop_and_async_reset();
    do_reset(2'b00, 24'd100);
    for (int k = 0; k < 50; k++) begin
      step_clk();
    end
    checks++;
    if (leds !== 4'b0001 || tick !== 1'b0) begin
      $display("FAIL long_period: leds=%b tick=%b, want leds=0001 tick=0", leds, tick);
      fails++;
    end
    period = 24'd10;
    step_clk();
    checks++;
    if (leds !== 4'b0010 || tick !== 1'b1) begin
      $display("FAIL period_drop: leds=%b tick=%b, want leds=0010 tick=1", leds, tick);
      fails++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (leds !== 4'b0001 || tick !== 1'b0) begin
      $display("FAIL async_reset: leds=%b tick=%b, want leds=0001 tick=0", leds, tick);
      fails++;
    end
    step_clk();
    checks++;
    if (leds !== 4'b0001 || tick !== 1'b0) begin
      $display("FAIL reset_hold: leds=%b tick=%b, want leds=0001 tick=0", leds, tick);
      fails++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    period = 24'd0;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_fill_mode_change();
    test_enable_freeze();
    test_period_drop_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
